// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed Thumb program over a UART byte
// stream and writes it halfword by halfword into CPU program memory.
// Frame: A5, LEN_LO, LEN_HI, LEN x (lo, hi), CHK = XOR of all data bytes.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   rx_valid, rx_data   - one-cycle received-byte strobe and byte
//   download_program    - holds the CPU in program-download mode
//   instruction_index   - halfword address of program_in
//   program_in          - halfword to store
//   busy                - frame in progress
//   load_done           - one-cycle pulse on a good frame
//   load_error          - level, last frame failed
module uart_program_loader #(
    parameter logic [31:0] BASE_INDEX     = 32'd0,
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // The idle counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SYNC = 8'hA5;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   k_q, k_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          dl_q, dl_d;
    logic [31:0]   idx_q, idx_d;
    logic [15:0]   prog_q, prog_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [15:0]   len_w;
    logic          len_big;
    logic          in_frame;

    assign len_w   = {rx_data, len_q[7:0]};
    assign len_big = {16'd0, len_w} > MAX_WORDS;
    assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                      (state_q == S_CHECK);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lo_d    = lo_q;
        k_d     = k_q;
        chk_d   = chk_q;
        tmo_d   = tmo_q;
        dl_d    = dl_q;
        idx_d   = idx_q;
        prog_d  = prog_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d = S_LEN_LO;
                    dl_d    = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    k_d         = 16'd0;
                    chk_d       = 8'd0;
                    if (len_w == 16'd0)
                        state_d = S_CHECK;
                    else if (len_big)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    prog_d  = {rx_data, lo_q};
                    idx_d   = BASE_INDEX + {16'd0, k_q};
                    k_d     = k_q + 16'd1;
                    chk_d   = chk_q ^ rx_data;
                    state_d = (k_q + 16'd1 == len_q) ? S_CHECK : S_DATA_LO;
                end
            end
            S_CHECK: begin
                if (rx_valid)
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                // Bytes arriving here are dropped.
                state_d = S_IDLE;
                dl_d    = 1'b0;
                err_d   = 1'b0;
            end
            S_ERROR: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d = S_LEN_LO;
                    dl_d    = 1'b1;
                    err_d   = 1'b0;
                end
            end
        endcase

        // Inter-byte idle watchdog, active only inside a frame.
        if (rx_valid || !in_frame) begin
            tmo_d = '0;
        end else if (tmo_q == T_LAST) begin
            tmo_d   = '0;
            state_d = S_ERROR;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (state_d == S_ERROR)
            err_d = 1'b1;

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                 (state_d == S_DATA_LO) || (state_d == S_DATA_HI) ||
                 (state_d == S_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            lo_q    <= '0;
            k_q     <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            dl_q    <= 1'b0;
            idx_q   <= '0;
            prog_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            k_q     <= k_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            dl_q    <= dl_d;
            idx_q   <= idx_d;
            prog_q  <= prog_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign download_program  = dl_q;
    assign instruction_index = idx_q;
    assign program_in        = prog_q;
    assign busy              = busy_q;
    assign load_done         = done_q;
    assign load_error        = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: two instances (BASE_INDEX 10 and
// 0xFFFFFFFF) share one byte stream; writes and frame results are scored.
module tb_uart_program_loader;

    localparam int MAXW = 256;
    localparam int TMO  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        dl_a, busy_a, done_a, err_a;
    logic [31:0] idx_a;
    logic [15:0] prog_a;
    logic        dl_b, busy_b, done_b, err_b;
    logic [31:0] idx_b;
    logic [15:0] prog_b;

    always #5 clk = ~clk;

    uart_program_loader #(
        .BASE_INDEX(32'd10),
        .MAX_WORDS(MAXW),
        .TIMEOUT_CYCLES(TMO)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .download_program(dl_a),
        .instruction_index(idx_a),
        .program_in(prog_a),
        .busy(busy_a),
        .load_done(done_a),
        .load_error(err_a)
    );

    uart_program_loader #(
        .BASE_INDEX(32'hFFFF_FFFF),
        .MAX_WORDS(MAXW),
        .TIMEOUT_CYCLES(TMO)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .download_program(dl_b),
        .instruction_index(idx_b),
        .program_in(prog_b),
        .busy(busy_b),
        .load_done(done_b),
        .load_error(err_b)
    );

    int errors = 0;
    int checks = 0;

    logic [47:0] exp_a[$];
    logic [47:0] exp_b[$];
    bit          res_a[$];
    bit          res_b[$];
    logic [15:0] words[$];

    bit          last_ok = 1'b0;
    int          last_k = 0;
    logic [15:0] last_w = 16'h0;
    int          gmax = 3;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a change of {index, program_in} is a write; load_done or a
    // rising load_error is a frame result.
    initial begin
        logic [47:0] pa, pb, ca, cb;
        logic        ea, eb;
        pa = '0; pb = '0; ea = 1'b0; eb = 1'b0;
        forever begin
            @(negedge clk);
            ca = {idx_a, prog_a};
            cb = {idx_b, prog_b};
            if (!rst) begin
                if (ca != pa) begin
                    if (exp_a.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL write_a: got %0h expected none", ca);
                    end else check("write_a", ca, exp_a.pop_front());
                end
                if (cb != pb) begin
                    if (exp_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL write_b: got %0h expected none", cb);
                    end else check("write_b", cb, exp_b.pop_front());
                end
                if (done_a || (err_a && !ea)) begin
                    if (res_a.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL result_a: got %0b expected none",
                                 {err_a, done_a});
                    end else
                        check("result_a", {err_a, done_a},
                              res_a.pop_front() ? 2'b01 : 2'b10);
                end
                if (done_b || (err_b && !eb)) begin
                    if (res_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL result_b: got %0b expected none",
                                 {err_b, done_b});
                    end else
                        check("result_b", {err_b, done_b},
                              res_b.pop_front() ? 2'b01 : 2'b10);
                end
            end
            pa = ca; pb = cb; ea = err_a; eb = err_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    function automatic int gap();
        return int'($urandom_range(0, gmax));
    endfunction

    // Reference model: every complete halfword i of an accepted length is
    // written at BASE+i; the frame succeeds only with the right checksum.
    task automatic frame(input int len, input bit bad, input bit fixed,
                         input bit poke);
        logic [7:0]  chk;
        logic [15:0] w;
        logic [15:0] lf;
        logic [31:0] ia, ib;
        bit          ok;
        chk = 8'h00;
        lf  = 16'(len);
        ok  = (len <= MAXW);
        if (!fixed) begin
            words.delete();
            for (int i = 0; i < len && ok; i++) begin
                w = 16'($urandom);
                if (i == 0 && last_ok && last_k == 0 && last_w == w)
                    w ^= 16'h0001;
                words.push_back(w);
            end
        end
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                w  = words[i];
                ia = 32'd10 + 32'(i);
                ib = 32'hFFFF_FFFF + 32'(i);
                exp_a.push_back({ia, w});
                exp_b.push_back({ib, w});
                chk ^= w[7:0] ^ w[15:8];
                last_ok = 1'b1;
                last_k  = i;
                last_w  = w;
            end
        end
        res_a.push_back(ok && !bad);
        res_b.push_back(ok && !bad);

        send(8'hA5, gap());
        check("dl_after_hdr", dl_a, 1);
        check("busy_after_hdr", busy_a, 1);
        check("err_cleared_hdr", err_a, 0);
        send(lf[7:0], gap());
        send(lf[15:8], 0);
        if (!ok) begin
            check("len_err", err_a, 1);
            check("len_err_busy", busy_a, 0);
            check("len_err_dl", dl_a, 1);
            return;
        end
        for (int i = 0; i < len; i++) begin
            send(words[i][7:0], gap());
            send(words[i][15:8], gap());
        end
        if (bad)
            send(fixed ? 8'h00 : chk ^ 8'($urandom_range(1, 255)), 0);
        else
            send(chk, 0);
        if (bad) begin
            check("chk_err", err_a, 1);
            check("chk_err_busy", busy_a, 0);
            check("chk_err_dl", dl_a, 1);
        end else begin
            check("done_pulse", done_a, 1);
            check("dl_in_done", dl_a, 1);
            check("busy_in_done", busy_a, 0);
            if (poke) begin
                send(8'hA5, 0);
                check("drop_busy", busy_a, 0);
                check("drop_dl", dl_a, 0);
            end else begin
                @(negedge clk);
            end
            check("dl_after_done", dl_a, 0);
            check("err_after_done", err_a, 0);
            check("done_one_cycle", done_a, 0);
        end
    endtask

    initial begin
        logic [7:0] g;
        int         kind;
        int         len;

        @(negedge clk);
        @(negedge clk);
        check("rst_dl", dl_a, 0);
        check("rst_idx_a", idx_a, 0);
        check("rst_idx_b", idx_b, 0);
        check("rst_prog", prog_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        rst = 1'b0;
        @(negedge clk);

        g = 8'h00; send(g, 0);
        check("garb00_busy", busy_a, 0); check("garb00_dl", dl_a, 0);
        g = 8'hFF; send(g, 0);
        check("garbFF_busy", busy_a, 0); check("garbFF_dl", dl_a, 0);
        g = 8'h5A; send(g, 1);
        check("garb5A_busy", busy_a, 0); check("garb5A_dl", dl_a, 0);

        // Reset in the middle of a frame after one halfword.
        exp_a.push_back({32'd10, 16'h2005});
        exp_b.push_back({32'hFFFF_FFFF, 16'h2005});
        send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
        send(8'h05, 0); send(8'h20, 0);
        check("mid_prog", prog_a, 16'h2005);
        check("mid_idx", idx_a, 10);
        #1 rst = 1'b1;
        #1;
        check("arst_dl", dl_a, 0);
        check("arst_idx", idx_a, 0);
        check("arst_prog", prog_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_err", err_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_ok = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy_a, 0);
        check("post_rst_dl", dl_a, 0);
        check("post_rst_prog", prog_a, 0);

        // Known frame, bad checksum first, then good, then drop test.
        words.delete();
        words.push_back(16'h2005);
        words.push_back(16'h1FC2);
        frame(2, 1'b1, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b1, 1'b1);

        frame(0, 1'b0, 1'b0, 1'b0);
        frame(257, 1'b0, 1'b0, 1'b0);
        gmax = 1;
        frame(MAXW, 1'b0, 1'b0, 1'b0);
        gmax = 3;

        // Idle stall after a low byte.
        res_a.push_back(1'b0);
        res_b.push_back(1'b0);
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_before", err_a, 0);
        check("tmo_busy_before", busy_a, 1);
        @(negedge clk);
        check("tmo_err", err_a, 1);
        check("tmo_busy", busy_a, 0);
        check("tmo_dl", dl_a, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send(g, gap());
            end
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 8));
            if (kind == 8) len = 0;
            if (kind == 9)
                len = ($urandom_range(0, 1) == 0) ?
                      MAXW + 1 + int'($urandom_range(0, 3)) : 65535;
            frame(len, kind == 6 || kind == 7, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("exp_a_empty", exp_a.size(), 0);
        check("exp_b_empty", exp_b.size(), 0);
        check("res_a_empty", res_a.size(), 0);
        check("res_b_empty", res_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
